// File: rtl/pin_entry_ctrl_pkg.sv
// Shared definitions for the PIN entry front-end: authenticator status encodings,
// keypad codes and controller state encoding.
package pin_entry_ctrl_pkg;

   localparam logic ACCOUNT_FOUND             = 1'b1;
   localparam logic ACCOUNT_NOT_FOUND         = 1'b0;
   localparam logic ACCOUNT_AUTHENTICATED     = 1'b1;
   localparam logic ACCOUNT_NOT_AUTHENTICATED = 1'b0;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;

   localparam logic [2:0] PIN_DIGITS = 3'd4;

   typedef enum logic [2:0] {
      StIdle,
      StCollect,
      StCheck,
      StGranted,
      StLocked
   } state_e;

   // Codes 0-9 are PIN digits; everything above is a control or unused key.
   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/pin_entry_ctrl_shift_reg.sv
// pin_shift_reg: 4-digit BCD shift register with digit counter. New digits enter at the
// bottom so the first digit ends up in pin_o[15:12]; shifts beyond four digits are dropped.
module pin_shift_reg
   import pin_entry_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        shift_i,
   input  logic [3:0]  digit_i,
   output logic [15:0] pin_o,
   output logic [2:0]  cnt_o
);

   logic [15:0] pin_q, pin_d;
   logic [2:0]  cnt_q, cnt_d;

   // Next-state: clear wins over shift; saturate at four digits.
   always_comb begin
      pin_d = pin_q;
      cnt_d = cnt_q;
      if (clr_i) begin
         pin_d = '0;
         cnt_d = '0;
      end else if (shift_i && (cnt_q < PIN_DIGITS)) begin
         pin_d = {pin_q[11:0], digit_i};
         cnt_d = cnt_q + 3'd1;
      end
   end

   // Digit storage and count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pin_q <= '0;
         cnt_q <= '0;
      end else begin
         pin_q <= pin_d;
         cnt_q <= cnt_d;
      end
   end

   assign pin_o = pin_q;
   assign cnt_o = cnt_q;

endmodule

// File: rtl/pin_entry_ctrl.sv
// pin_entry_ctrl: captures card account number and keypad PIN, requests authentication,
// grants a session or counts failed attempts and locks the terminal.
// Optional feature macro LOCKOUT_TIMER_EN: LOCKED self-clears after LOCK_CYCLES clocks;
// without it LOCKED is held until reset.
module pin_entry_ctrl
   import pin_entry_ctrl_pkg::*;
#(
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned AUTH_LAT    = 1,
   parameter int unsigned LOCK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        card_in,
   input  logic [3:0]  acc_num_in,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        acc_found_stat,
   input  logic        acc_auth_stat,
   output logic [3:0]  acc_num,
   output logic [15:0] pin,
   output logic        auth_req,
   output logic        session_ok,
   output logic        auth_fail,
   output logic        bad_card,
   output logic        locked,
   output logic [1:0]  tries_left,
   output logic [2:0]  digit_cnt
);

   if (MAX_TRIES < 1 || MAX_TRIES > 3 || AUTH_LAT < 1 || AUTH_LAT > 7 || LOCK_CYCLES < 1)
   begin : g_param_check
      $error("pin_entry_ctrl: parameter out of range");
   end

   state_e     state_q, state_d;
   logic [3:0] acc_q, acc_d;
   logic [1:0] tries_q, tries_d;
   logic [2:0] lat_q, lat_d;
   logic       fail_q, fail_d;
   logic       bad_q, bad_d;
   logic       pin_clr, pin_shift;

`ifdef LOCKOUT_TIMER_EN
   localparam int unsigned LockW = $clog2(LOCK_CYCLES + 1);
   logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
`endif

   pin_shift_reg u_pin_shift_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (pin_clr),
      .shift_i (pin_shift),
      .digit_i (key_code),
      .pin_o   (pin),
      .cnt_o   (digit_cnt)
   );

   // Next-state and datapath control; card removal takes priority over keys and sampling.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      tries_d   = tries_q;
      lat_d     = lat_q;
      fail_d    = 1'b0;
      bad_d     = 1'b0;
      pin_clr   = 1'b0;
      pin_shift = 1'b0;
`ifdef LOCKOUT_TIMER_EN
      lock_cnt_d = '0;
`endif
      unique case (state_q)
         StIdle: begin
            pin_clr = 1'b1;
            if (card_in) begin
               acc_d   = acc_num_in;
               tries_d = 2'(MAX_TRIES);
               state_d = StCollect;
            end
         end
         StCollect: begin
            if (!card_in) begin
               pin_clr = 1'b1;
               state_d = StIdle;
            end else if (key_valid) begin
               if (is_digit(key_code)) begin
                  pin_shift = 1'b1;
               end else if (key_code == KEY_CLEAR) begin
                  pin_clr = 1'b1;
               end else if (key_code == KEY_ENTER && digit_cnt == PIN_DIGITS) begin
                  lat_d   = '0;
                  state_d = StCheck;
               end
            end
         end
         StCheck: begin
            if (!card_in) begin
               pin_clr = 1'b1;
               state_d = StIdle;
            end else if (lat_q == 3'(AUTH_LAT - 1)) begin
               if (acc_found_stat == ACCOUNT_NOT_FOUND) begin
                  bad_d   = 1'b1;
                  pin_clr = 1'b1;
                  state_d = StIdle;
               end else if (acc_auth_stat == ACCOUNT_AUTHENTICATED) begin
                  state_d = StGranted;
               end else begin
                  tries_d = tries_q - 2'd1;
                  pin_clr = 1'b1;
                  if (tries_q == 2'd1) begin
                     state_d = StLocked;
                  end else begin
                     fail_d  = 1'b1;
                     state_d = StCollect;
                  end
               end
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end
         StGranted: begin
            if (!card_in) begin
               pin_clr = 1'b1;
               state_d = StIdle;
            end
         end
         StLocked: begin
            pin_clr = 1'b1;
`ifdef LOCKOUT_TIMER_EN
            if (lock_cnt_q == LockW'(LOCK_CYCLES - 1)) begin
               state_d = StIdle;
            end else begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            pin_clr = 1'b1;
            state_d = StIdle;
         end
      endcase
   end

   // Controller state, latched account, try counter, latency counter and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
         tries_q <= '0;
         lat_q   <= '0;
         fail_q  <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         tries_q <= tries_d;
         lat_q   <= lat_d;
         fail_q  <= fail_d;
         bad_q   <= bad_d;
      end
   end

`ifdef LOCKOUT_TIMER_EN
   // Lockout duration counter, only runs while LOCKED.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt_q <= '0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
      end
   end
`endif

   assign acc_num    = acc_q;
   assign tries_left = tries_q;
   assign auth_fail  = fail_q;
   assign bad_card   = bad_q;
   assign auth_req   = (state_q == StCheck);
   assign session_ok = (state_q == StGranted);
   assign locked     = (state_q == StLocked);

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Directed bench for pin_entry_ctrl: a vector table for the main flow plus hand-written
// sequences for bad card, lockout, card removal and asynchronous reset.
module tb_pin_entry_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        card_in = 1'b0;
   logic [3:0]  acc_num_in = '0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = '0;
   logic        acc_found_stat = 1'b1;
   logic        acc_auth_stat = 1'b1;
   logic [3:0]  acc_num;
   logic [15:0] pin;
   logic        auth_req, session_ok, auth_fail, bad_card, locked;
   logic [1:0]  tries_left;
   logic [2:0]  digit_cnt;

   int tests = 0;
   int fails = 0;

   pin_entry_ctrl #(
      .MAX_TRIES   (3),
      .AUTH_LAT    (1),
      .LOCK_CYCLES (10)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .card_in        (card_in),
      .acc_num_in     (acc_num_in),
      .key_valid      (key_valid),
      .key_code       (key_code),
      .acc_found_stat (acc_found_stat),
      .acc_auth_stat  (acc_auth_stat),
      .acc_num        (acc_num),
      .pin            (pin),
      .auth_req       (auth_req),
      .session_ok     (session_ok),
      .auth_fail      (auth_fail),
      .bad_card       (bad_card),
      .locked         (locked),
      .tries_left     (tries_left),
      .digit_cnt      (digit_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        card;
      logic [3:0]  acc;
      logic        kv;
      logic [3:0]  kc;
      logic        found;
      logic        auth;
      logic [29:0] exp;
   } vec_t;

   // Packed output view: {pin, digit_cnt, auth_req, session_ok, auth_fail, bad_card,
   // locked, tries_left, acc_num}.
   function automatic logic [29:0] outs();
      return {pin, digit_cnt, auth_req, session_ok, auth_fail, bad_card, locked,
              tries_left, acc_num};
   endfunction

   function automatic vec_t mk(input logic card, input logic [3:0] acc, input logic kv,
                               input logic [3:0] kc, input logic found, input logic auth,
                               input logic [15:0] p, input logic [2:0] cnt,
                               input logic req, input logic sess, input logic fail,
                               input logic bad, input logic lock, input logic [1:0] tries,
                               input logic [3:0] accn);
      vec_t v;
      v.card  = card;
      v.acc   = acc;
      v.kv    = kv;
      v.kc    = kc;
      v.found = found;
      v.auth  = auth;
      v.exp   = {p, cnt, req, sess, fail, bad, lock, tries, accn};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // One clock: inputs already set, sample just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic card, input logic [3:0] acc, input logic kv,
                        input logic [3:0] kc);
      card_in    = card;
      acc_num_in = acc;
      key_valid  = kv;
      key_code   = kc;
   endtask

   task automatic do_reset();
      drive(1'b0, 4'd0, 1'b0, 4'd0);
      acc_found_stat = 1'b1;
      acc_auth_stat  = 1'b1;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic enter_pin(input logic [3:0] acc);
      drive(1'b1, acc, 1'b0, 4'd0);
      step();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, acc, 1'b1, 4'(i));
         step();
      end
   endtask

   vec_t tbl[35];

   initial begin
      // Good PIN with digit saturation, clear and early enter, then session and removal.
      tbl[0]  = mk(1, 3, 0, 4'h0, 1, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 3, 3);
      tbl[1]  = mk(1, 3, 1, 4'h1, 1, 1, 16'h0001, 1, 0, 0, 0, 0, 0, 3, 3);
      tbl[2]  = mk(1, 3, 1, 4'h2, 1, 1, 16'h0012, 2, 0, 0, 0, 0, 0, 3, 3);
      tbl[3]  = mk(1, 3, 1, 4'h3, 1, 1, 16'h0123, 3, 0, 0, 0, 0, 0, 3, 3);
      tbl[4]  = mk(1, 3, 1, 4'h4, 1, 1, 16'h1234, 4, 0, 0, 0, 0, 0, 3, 3);
      tbl[5]  = mk(1, 3, 1, 4'h5, 1, 1, 16'h1234, 4, 0, 0, 0, 0, 0, 3, 3);
      tbl[6]  = mk(1, 3, 1, 4'hA, 1, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 3, 3);
      tbl[7]  = mk(1, 3, 1, 4'h1, 1, 1, 16'h0001, 1, 0, 0, 0, 0, 0, 3, 3);
      tbl[8]  = mk(1, 3, 1, 4'h2, 1, 1, 16'h0012, 2, 0, 0, 0, 0, 0, 3, 3);
      tbl[9]  = mk(1, 3, 1, 4'h3, 1, 1, 16'h0123, 3, 0, 0, 0, 0, 0, 3, 3);
      tbl[10] = mk(1, 3, 1, 4'hB, 1, 1, 16'h0123, 3, 0, 0, 0, 0, 0, 3, 3);
      tbl[11] = mk(1, 3, 1, 4'h4, 1, 1, 16'h1234, 4, 0, 0, 0, 0, 0, 3, 3);
      tbl[12] = mk(1, 3, 1, 4'hB, 1, 1, 16'h1234, 4, 1, 0, 0, 0, 0, 3, 3);
      tbl[13] = mk(1, 3, 0, 4'h0, 1, 1, 16'h1234, 4, 0, 1, 0, 0, 0, 3, 3);
      tbl[14] = mk(1, 3, 1, 4'h7, 1, 1, 16'h1234, 4, 0, 1, 0, 0, 0, 3, 3);
      tbl[15] = mk(0, 3, 0, 4'h0, 1, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 3, 3);
      // Three wrong PINs on a new card.
      tbl[16] = mk(1, 5, 0, 4'h0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 3, 5);
      tbl[17] = mk(1, 5, 1, 4'h9, 1, 0, 16'h0009, 1, 0, 0, 0, 0, 0, 3, 5);
      tbl[18] = mk(1, 5, 1, 4'h8, 1, 0, 16'h0098, 2, 0, 0, 0, 0, 0, 3, 5);
      tbl[19] = mk(1, 5, 1, 4'h7, 1, 0, 16'h0987, 3, 0, 0, 0, 0, 0, 3, 5);
      tbl[20] = mk(1, 5, 1, 4'h6, 1, 0, 16'h9876, 4, 0, 0, 0, 0, 0, 3, 5);
      tbl[21] = mk(1, 5, 1, 4'hB, 1, 0, 16'h9876, 4, 1, 0, 0, 0, 0, 3, 5);
      tbl[22] = mk(1, 5, 0, 4'h0, 1, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 2, 5);
      tbl[23] = mk(1, 5, 1, 4'h1, 1, 0, 16'h0001, 1, 0, 0, 0, 0, 0, 2, 5);
      tbl[24] = mk(1, 5, 1, 4'h2, 1, 0, 16'h0012, 2, 0, 0, 0, 0, 0, 2, 5);
      tbl[25] = mk(1, 5, 1, 4'h3, 1, 0, 16'h0123, 3, 0, 0, 0, 0, 0, 2, 5);
      tbl[26] = mk(1, 5, 1, 4'h4, 1, 0, 16'h1234, 4, 0, 0, 0, 0, 0, 2, 5);
      tbl[27] = mk(1, 5, 1, 4'hB, 1, 0, 16'h1234, 4, 1, 0, 0, 0, 0, 2, 5);
      tbl[28] = mk(1, 5, 0, 4'h0, 1, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 1, 5);
      tbl[29] = mk(1, 5, 1, 4'h1, 1, 0, 16'h0001, 1, 0, 0, 0, 0, 0, 1, 5);
      tbl[30] = mk(1, 5, 1, 4'h1, 1, 0, 16'h0011, 2, 0, 0, 0, 0, 0, 1, 5);
      tbl[31] = mk(1, 5, 1, 4'h1, 1, 0, 16'h0111, 3, 0, 0, 0, 0, 0, 1, 5);
      tbl[32] = mk(1, 5, 1, 4'h1, 1, 0, 16'h1111, 4, 0, 0, 0, 0, 0, 1, 5);
      tbl[33] = mk(1, 5, 1, 4'hB, 1, 0, 16'h1111, 4, 1, 0, 0, 0, 0, 1, 5);
      tbl[34] = mk(1, 5, 0, 4'h0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 5);

      do_reset();
      check("reset_state", 32'(outs()), 32'd0);

      for (int i = 0; i < 35; i++) begin
         drive(tbl[i].card, tbl[i].acc, tbl[i].kv, tbl[i].kc);
         acc_found_stat = tbl[i].found;
         acc_auth_stat  = tbl[i].auth;
         step();
         check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      end

      // Locked: keys and card removal have no effect.
      begin
         int n;
         n = 1;
         drive(1'b0, 4'd5, 1'b1, 4'h1);
         step();
         check("lock_key_ignored", 32'(outs()), 32'({16'h0, 3'd0, 5'b00001, 2'd0, 4'd5}));
         if (locked) n++;
         drive(1'b0, 4'd5, 1'b0, 4'h0);
`ifdef LOCKOUT_TIMER_EN
         for (int i = 0; i < 20 && locked; i++) begin
            step();
            if (locked) n++;
         end
         check("lock_duration", 32'(n), 32'd10);
         check("lock_release", 32'(outs()), 32'({16'h0, 3'd0, 5'b00000, 2'd0, 4'd5}));
`else
         for (int i = 0; i < 100; i++) begin
            drive(i >= 50, 4'd5, i[0], 4'hB);
            step();
            if (locked) n++;
         end
         check("lock_held", 32'(n), 32'd102);
         check("lock_state", 32'(outs()), 32'({16'h0, 3'd0, 5'b00001, 2'd0, 4'd5}));
`endif
      end

      // Account not found at the sample cycle.
      do_reset();
      enter_pin(4'd7);
      drive(1'b1, 4'd7, 1'b1, 4'hB);
      step();
      check("bad_req", 32'(auth_req), 32'd1);
      drive(1'b1, 4'd7, 1'b0, 4'h0);
      acc_found_stat = 1'b0;
      step();
      check("bad_pulse", 32'(outs()), 32'({16'h0, 3'd0, 5'b00010, 2'd3, 4'd7}));
      drive(1'b0, 4'd7, 1'b0, 4'h0);
      acc_found_stat = 1'b1;
      step();
      check("bad_after", 32'(outs()), 32'({16'h0, 3'd0, 5'b00000, 2'd3, 4'd7}));

      // Card removed in the same cycle as enter.
      do_reset();
      enter_pin(4'd2);
      drive(1'b0, 4'd2, 1'b1, 4'hB);
      step();
      check("remove_enter", 32'(outs()), 32'({16'h0, 3'd0, 5'b00000, 2'd3, 4'd2}));
      drive(1'b0, 4'd2, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("remove_noreq%0d", i), 32'(auth_req), 32'd0);
      end

      // Asynchronous reset while waiting on the authenticator.
      do_reset();
      enter_pin(4'd9);
      drive(1'b1, 4'd9, 1'b1, 4'hB);
      step();
      check("chk_req", 32'(outs()), 32'({16'h1234, 3'd4, 5'b10000, 2'd3, 4'd9}));
      drive(1'b1, 4'd9, 1'b0, 4'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", 32'(outs()), 32'd0);
      step();
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
